// File: rtl/branch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_pkg: branch opcodes and default sizes for branch_unit         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package branch_pkg;

   // Codes 6 and 7 are reserved and decode exactly like BR_NONE.
   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_JMP  = 3'd3,
      BR_CALL = 3'd4,
      BR_RET  = 3'd5
   } br_op_t;

   localparam int LUT_N_DEF = 16;
   localparam int RAS_N_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/branch_unit_ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ret_stack: LIFO return-address stack; top entry is entry[Depth-1]    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ret_stack #(
   parameter  int L     = 10,
   parameter  int RAS_N = 4,
   localparam int DW    = $clog2(RAS_N + 1)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Push,
   input  logic          Pop,
   input  logic [L-1:0]  PushData,
   output logic [L-1:0]  Top,
   output logic [DW-1:0] Depth,
   output logic          Full,
   output logic          Empty
);

   logic [L-1:0]  mem_q [RAS_N];
   logic [L-1:0]  mem_d [RAS_N];
   logic [DW-1:0] depth_q, depth_d;

   // Callers never push when full nor pop when empty.
   always_comb begin
      mem_d   = mem_q;
      depth_d = depth_q;
      if (Push) begin
         for (int i = 0; i < RAS_N; i++) begin
            if (depth_q == DW'(i)) mem_d[i] = PushData;
         end
         depth_d = depth_q + DW'(1);
      end else if (Pop) begin
         depth_d = depth_q - DW'(1);
      end
   end

   always_comb begin
      Top = '0;
      for (int i = 0; i < RAS_N; i++) begin
         if (depth_q == DW'(i + 1)) Top = mem_q[i];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < RAS_N; i++) mem_q[i] <= '0;
         depth_q <= '0;
      end else begin
         mem_q   <= mem_d;
         depth_q <= depth_d;
      end
   end

   assign Depth = depth_q;
   assign Full  = (depth_q == DW'(RAS_N));
   assign Empty = (depth_q == '0);

endmodule
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_unit: decides PC jump/target from zero flag, LUT and stack    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module branch_unit
   import branch_pkg::*;
#(
   parameter  int L     = 10,
   parameter  int LUT_N = LUT_N_DEF,
   parameter  int RAS_N = RAS_N_DEF,
   localparam int LI    = $clog2(LUT_N),
   localparam int DW    = $clog2(RAS_N + 1)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic [L-1:0]  ProgCtr,
   input  br_op_t        BrOp,
   input  logic [LI-1:0] LutIdx,
   input  logic          FlagWe,
   input  logic          ZeroIn,
   input  logic          LutWe,
   input  logic [LI-1:0] LutWrIdx,
   input  logic [L-1:0]  LutWrData,
   output logic [L-1:0]  Target,
   output logic          BaddEn,
   output logic          Zero,
   output logic [DW-1:0] Depth,
   output logic          StackOvf,
   output logic          StackUnf
);

   logic [L-1:0] lut_q [LUT_N];
   logic [L-1:0] lut_d [LUT_N];
   logic         flag_q, flag_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;

   logic         push, pop;
   logic [L-1:0] stk_top;
   logic         stk_full, stk_empty;
   logic [L-1:0] lut_rd;

   assign lut_rd = lut_q[LutIdx];

   always_comb begin
      lut_d = lut_q;
      if (LutWe) lut_d[LutWrIdx] = LutWrData;
      flag_d = FlagWe ? ZeroIn : flag_q;
   end

   // Output decode; Start and Reset both force a no-branch cycle.
   always_comb begin
      Target = '0;
      BaddEn = 1'b0;
      Zero   = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      if (!Reset && !Start) begin
         case (BrOp)
            BR_BEQ: begin
               BaddEn = 1'b1;
               Zero   = flag_q;
               Target = lut_rd;
            end
            BR_BNE: begin
               BaddEn = 1'b1;
               Zero   = ~flag_q;
               Target = lut_rd;
            end
            BR_JMP: begin
               BaddEn = 1'b1;
               Zero   = 1'b1;
               Target = lut_rd;
            end
            BR_CALL: begin
               if (!stk_full) begin
                  BaddEn = 1'b1;
                  Zero   = 1'b1;
                  Target = lut_rd;
                  push   = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            BR_RET: begin
               if (!stk_empty) begin
                  BaddEn = 1'b1;
                  Zero   = 1'b1;
                  Target = stk_top;
                  pop    = 1'b1;
               end else begin
                  unf_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
         flag_q <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         lut_q  <= lut_d;
         flag_q <= flag_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   ret_stack #(
      .L     (L),
      .RAS_N (RAS_N)
   ) u_ret_stack (
      .Clk      (Clk),
      .Reset    (Reset),
      .Push     (push),
      .Pop      (pop),
      .PushData (ProgCtr + L'(1)),
      .Top      (stk_top),
      .Depth    (Depth),
      .Full     (stk_full),
      .Empty    (stk_empty)
   );

   assign StackOvf = ovf_q;
   assign StackUnf = unf_q;

endmodule
`default_nettype wire
